// File: rtl/writeback_arbiter.sv
// Writeback arbiter: round-robin selection between ALU and load results,
// load-data alignment/extension, registered register-file write port and retire counter.
module writeback_arbiter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk_w_i,
  input  logic             res_w_i_h,
  input  logic             alu_valid_w_i,
  input  logic [4:0]       alu_rd_w_i,
  input  logic [31:0]      alu_data_w_i,
  output logic             alu_ready_w_o,
  input  logic             lsu_valid_w_i,
  input  logic [4:0]       lsu_rd_w_i,
  input  logic [31:0]      lsu_data_w_i,
  input  logic [1:0]       lsu_addr_w_i,
  input  logic [1:0]       lsu_size_w_i,
  input  logic             lsu_unsigned_w_i,
  output logic             lsu_ready_w_o,
  output logic             reg_wr_flag_w_o,
  output logic [4:0]       wr_reg_w_o,
  output logic [31:0]      wr_data_w_o,
  output logic             align_err_w_o,
  output logic [CNT_W-1:0] retired_w_o
);

  // Returns {misaligned, formatted_data}; misaligned loads pass the raw word through.
  function automatic logic [32:0] load_format(
    input logic [31:0] word,
    input logic [1:0]  addr,
    input logic [1:0]  size,
    input logic        uns
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    logic        err;
    b   = 8'h00;
    d   = word;
    err = 1'b0;
    case (addr)
      2'b00:   b = word[7:0];
      2'b01:   b = word[15:8];
      2'b10:   b = word[23:16];
      2'b11:   b = word[31:24];
      default: b = 8'h00;
    endcase
    h = addr[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00: d = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01: begin
        err = addr[0];
        d   = err ? word : (uns ? {16'h0000, h} : {{16{h[15]}}, h});
      end
      2'b10: begin
        err = (addr != 2'b00);
        d   = word;
      end
      default: begin
        err = 1'b1;
        d   = word;
      end
    endcase
    return {err, d};
  endfunction

  logic             last_gnt_q, last_gnt_d;   // 1 = ALU won the most recent two-way contest
  logic             flag_q, flag_d;
  logic [4:0]       reg_q, reg_d;
  logic [31:0]      data_q, data_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             alu_gnt_s;
  logic             lsu_gnt_s;
  logic [32:0]      lsu_fmt_s;

  // Grant selection: single requester wins outright, contests alternate.
  always_comb begin
    alu_gnt_s = 1'b0;
    lsu_gnt_s = 1'b0;
    if (res_w_i_h) begin
      alu_gnt_s = 1'b0;
      lsu_gnt_s = 1'b0;
    end else if (alu_valid_w_i && lsu_valid_w_i) begin
      alu_gnt_s = !last_gnt_q;
      lsu_gnt_s = last_gnt_q;
    end else begin
      alu_gnt_s = alu_valid_w_i;
      lsu_gnt_s = lsu_valid_w_i;
    end
  end

  assign lsu_fmt_s     = load_format(lsu_data_w_i, lsu_addr_w_i, lsu_size_w_i, lsu_unsigned_w_i);
  assign alu_ready_w_o = alu_gnt_s;
  assign lsu_ready_w_o = lsu_gnt_s;

  // Next-state for the write port, alignment pulse, counter and round-robin bit.
  always_comb begin
    last_gnt_d = last_gnt_q;
    flag_d     = 1'b0;
    reg_d      = reg_q;
    data_d     = data_q;
    err_d      = 1'b0;
    cnt_d      = cnt_q;
    if (alu_gnt_s) begin
      flag_d = (alu_rd_w_i != 5'd0);
      reg_d  = alu_rd_w_i;
      data_d = alu_data_w_i;
      cnt_d  = cnt_q + CNT_W'(1);
    end else if (lsu_gnt_s) begin
      err_d  = lsu_fmt_s[32];
      flag_d = (lsu_rd_w_i != 5'd0) && !lsu_fmt_s[32];
      reg_d  = lsu_rd_w_i;
      data_d = lsu_fmt_s[31:0];
      cnt_d  = cnt_q + CNT_W'(1);
    end else begin
      cnt_d  = cnt_q;
    end
    if (alu_valid_w_i && lsu_valid_w_i && !res_w_i_h) begin
      last_gnt_d = alu_gnt_s;
    end else begin
      last_gnt_d = last_gnt_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_w_i) begin
    if (res_w_i_h) begin
      last_gnt_q <= 1'b0;
      flag_q     <= 1'b0;
      reg_q      <= 5'd0;
      data_q     <= 32'h0000_0000;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      flag_q     <= flag_d;
      reg_q      <= reg_d;
      data_q     <= data_d;
      err_q      <= err_d;
      cnt_q      <= cnt_d;
    end
  end

  assign reg_wr_flag_w_o = flag_q;
  assign wr_reg_w_o      = reg_q;
  assign wr_data_w_o     = data_q;
  assign align_err_w_o   = err_q;
  assign retired_w_o     = cnt_q;

endmodule
